// File: rtl/regfile_mp.sv
// regfile_mp: NRD-read / 1-write integer register file, zero-filled by a hardware clear after reset.
// Latency: reads are registered (1 cycle); the clear takes NREGS edges and ready rises on the last one.
// Backpressure: stall holds every rsData port while writes continue; define REGFILE_BYPASS_EN for write-first forwarding.
module regfile_mp #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [AW-1:0]       rdAdrs,
  input  logic [XLEN-1:0]     rdData,
  input  logic [NRD*AW-1:0]   rsAdrs,
  input  logic                stall,
  output logic [NRD*XLEN-1:0] rsData,
  output logic                ready
);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [AW-1:0]   cnt;
  logic [XLEN-1:0] registers [NREGS];

  // Next state: leave CLEAR once the last register has been zeroed.
  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (cnt == AW'(NREGS - 1)) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // State, clear counter and ready flag; ready tracks the state we are entering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      state <= state_nxt;
      ready <= (state_nxt == RUN);
      if (state == CLEAR) cnt <= cnt + 1'b1;
    end
  end

  // Storage: the clear sequence owns the write port until RUN; x0 is never written by users.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        registers[cnt] <= '0;
      end else if (enable && (rdAdrs != '0)) begin
        registers[rdAdrs] <= rdData;
      end
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   adr;
    logic [XLEN-1:0] val;
    logic [XLEN-1:0] rd_q;

    assign adr = rsAdrs[i*AW +: AW];

    // Read mux: x0 is hard-wired to zero whatever the array holds.
    always_comb begin
      val = (adr == '0) ? '0 : registers[adr];
`ifdef REGFILE_BYPASS_EN
      if (enable && (rdAdrs != '0) && (rdAdrs == adr)) val = rdData;
`endif
    end

    // Output register: zero during reset/clear, frozen while stalled.
    always_ff @(posedge clk) begin
      if (rst || (state == CLEAR)) begin
        rd_q <= '0;
      end else if (!stall) begin
        rd_q <= val;
      end
    end

    assign rsData[i*XLEN +: XLEN] = rd_q;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed bench for regfile_mp with three read ports.
// Read expectations go into a scoreboard queue when driven and are popped after the edge.
// Outputs are sampled on the falling edge; inputs change there too.
module tb_regfile_mp;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 3;
  localparam int AW    = 5;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                enable = 1'b0;
  logic [AW-1:0]       rdAdrs = '0;
  logic [XLEN-1:0]     rdData = '0;
  logic [NRD*AW-1:0]   rsAdrs = '0;
  logic                stall = 1'b0;
  logic [NRD*XLEN-1:0] rsData;
  logic                ready;

  int checks = 0;
  int failures = 0;

  logic [NRD*XLEN-1:0] exp_q [$];
  string               tag_q [$];

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .rdAdrs (rdAdrs),
    .rdData (rdData),
    .rsAdrs (rsAdrs),
    .stall  (stall),
    .rsData (rsData),
    .ready  (ready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Drive one edge: optional write, three read addresses; expected port data queued, checked after the edge.
  task automatic rd(input string tag, input logic wen, input logic [AW-1:0] wa, input logic [XLEN-1:0] wd,
                    input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                    input logic [XLEN-1:0] e0, input logic [XLEN-1:0] e1, input logic [XLEN-1:0] e2);
    logic [NRD*XLEN-1:0] expv;
    string t;
    enable = wen;
    rdAdrs = wa;
    rdData = wd;
    rsAdrs = {a2, a1, a0};
    exp_q.push_back({e2, e1, e0});
    tag_q.push_back(tag);
    step();
    enable = 1'b0;
    expv = exp_q.pop_front();
    t = tag_q.pop_front();
    for (int p = 0; p < NRD; p++) begin
      check($sformatf("%s_p%0d", t, p), rsData[p*XLEN +: XLEN], expv[p*XLEN +: XLEN]);
    end
  endtask

  task automatic wr(input logic [AW-1:0] wa, input logic [XLEN-1:0] wd);
    enable = 1'b1;
    rdAdrs = wa;
    rdData = wd;
    step();
    enable = 1'b0;
  endtask

  // Count rst-free edges until ready rises; bounded so a stuck DUT still reaches the summary.
  task automatic count_clear(input string tag);
    int n;
    n = 0;
    while (n < 100) begin
      step();
      n++;
      if (ready === 1'b1) break;
    end
    checks++;
    assert (n == NREGS && ready === 1'b1) else begin
      failures++;
      $error("FAIL %s observed=%0d edges expected=%0d", tag, n, NREGS);
    end
  endtask

  initial begin
    // Reset, then a clear with user writes and stall asserted that must both be ignored.
    rst = 1'b1;
    step();
    checks++;
    assert (ready === 1'b0) else begin
      failures++;
      $error("FAIL reset_ready observed=%b expected=0", ready);
    end
    check("reset_rs0", rsData[0 +: XLEN], '0);
    check("reset_rs2", rsData[2*XLEN +: XLEN], '0);
    rst = 1'b0;
    enable = 1'b1;
    rdAdrs = 5'd5;
    rdData = 32'h0000_1234;
    stall = 1'b1;
    rsAdrs = {5'd5, 5'd5, 5'd5};
    count_clear("clear1_len");
    enable = 1'b0;
    stall = 1'b0;
    check("clear_rs_zero", rsData[0 +: XLEN], '0);
    rd("clear_write_ignored", 1'b0, 0, 0, 5, 5, 5, 0, 0, 0);

    // Reset clear: x5 written, then wiped by a one-cycle reset pulse.
    wr(5'd5, 32'hDEAD_BEEF);
    rd("x5_written", 1'b0, 0, 0, 5, 0, 5, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF);
    rst = 1'b1;
    step();
    rst = 1'b0;
    count_clear("clear2_len");
    rd("x5_cleared", 1'b0, 0, 0, 5, 5, 5, 0, 0, 0);

    // Basic write/read on three ports, including a shared address.
    wr(5'd1, 32'h11);
    wr(5'd2, 32'h22);
    wr(5'd3, 32'h33);
    rd("basic_rw", 1'b0, 0, 0, 3, 1, 3, 32'h33, 32'h11, 32'h33);
    rd("basic_rw2", 1'b0, 0, 0, 2, 2, 1, 32'h22, 32'h22, 32'h11);

    // x0 protection, same-edge and later.
    rd("x0_same_edge", 1'b1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0);
    rd("x0_after", 1'b0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Same-edge write/read on x7: forwarding depends on the build.
    wr(5'd7, 32'hA);
    rd("x7_same_edge", 1'b1, 7, 32'hB, 7, 1, 7,
       BYP ? 32'hB : 32'hA, 32'h11, BYP ? 32'hB : 32'hA);
    rd("x7_next", 1'b0, 0, 0, 7, 7, 7, 32'hB, 32'hB, 32'hB);

    // Stall holds outputs while writes continue.
    wr(5'd4, 32'h44);
    wr(5'd5, 32'h55);
    rd("pre_stall", 1'b0, 0, 0, 4, 4, 4, 32'h44, 32'h44, 32'h44);
    stall = 1'b1;
    rd("stall_c1", 1'b1, 4, 32'h99, 5, 5, 5, 32'h44, 32'h44, 32'h44);
    rd("stall_c2", 1'b0, 0, 0, 5, 5, 5, 32'h44, 32'h44, 32'h44);
    rd("stall_c3", 1'b0, 0, 0, 5, 5, 5, 32'h44, 32'h44, 32'h44);
    stall = 1'b0;
    rd("stall_release", 1'b0, 0, 0, 5, 5, 5, 32'h55, 32'h55, 32'h55);
    rd("x4_written_in_stall", 1'b0, 0, 0, 4, 5, 4, 32'h99, 32'h55, 32'h99);

    // Reset mid-clear at cnt=10 with writes pending, then full clear.
    rst = 1'b1;
    step();
    rst = 1'b0;
    enable = 1'b1;
    rdAdrs = 5'd9;
    rdData = 32'h77;
    for (int k = 0; k < 10; k++) step();
    checks++;
    assert (ready === 1'b0) else begin
      failures++;
      $error("FAIL midclear_ready observed=%b expected=0", ready);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    count_clear("clear3_len");
    enable = 1'b0;
    for (int r = 0; r < NREGS; r += 3) begin
      rd($sformatf("all_zero_r%0d", r), 1'b0, 0, 0,
         AW'(r), AW'((r + 1) % NREGS), AW'((r + 2) % NREGS), 0, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parameterised, multi-read-port integer register file for the RISC-V core: the generalised successor of the single-write, two-read register file. Supports configurable data width, register count and read-port count. Adds synchronous reset with a hardware clear sequence, a `ready` flag and a read-stall hold. Optional write-to-read bypass is selectable at compile time. Sits between decode (read addresses) and writeback (write port).

## Interface
- `XLEN`, default 32: register width in bits.
- `NREGS`, default 32: number of registers.
  - Power of two, ≥ 2.
  - `AW = $clog2(NREGS)` is a derived localparam, not overridable.
- `NRD`, default 2: number of read ports, ≥ 1.

Ports:
- `clk`  in  1  : single clock; all state updates on its rising edge.
- `rst`  in  1  : synchronous, active-high reset.
- `enable`  in  1  : write enable.
- `rdAdrs`  in  AW  : write address.
- `rdData`  in  XLEN  : write data.
- `rsAdrs`  in  NRD*AW  : packed read addresses; port i at bits `[i*AW +: AW]`.
- `stall`  in  1  : when high, all `rsData` hold their value.
- `rsData`  out  NRD*XLEN  : registered read data; port i at bits `[i*XLEN +: XLEN]`.
- `ready`  out  1  : high once the clear sequence has completed.

## Operation
- **Reset:**
  - Any edge with `rst`=1 sets state CLEAR, clear counter `cnt`=0, `ready`=0 and all `rsData`=0.
  - `rst` has priority over every other input.
- **State CLEAR:**
  - On each edge with `rst`=0, write 0 to `registers[cnt]` and increment `cnt`.
  - On the edge that clears `NREGS-1`, go to RUN and set `ready`=1.
  - `enable` is ignored, so no user write lands.
  - `rsData` is forced to 0; `stall` is ignored.
- **State RUN:**
  - **Write:** if `enable`=1 and `rdAdrs`≠0, `registers[rdAdrs] <= rdData`.
  - **Register 0:** reads as 0 and is never written, regardless of stored content.
  - **Read, `stall`=0:** on each edge, for each port i, `rsData[i] <= registers[rsAdrs[i]]`.
    - Address 0 always returns 0.
    - With bypass configured (see Configuration), a same-edge write to the read address returns `rdData`.
  - **Read, `stall`=1:** `rsData` unchanged; writes still occur.
- **Other rules:**
  - Any number of read ports may address the same register; all receive identical data.
  - `rst` during CLEAR or RUN restarts CLEAR at `cnt`=0.

## Timing
- **Reset values:** `rsData`=0, `ready`=0.
- **Clear duration:** `ready` rises on the NREGS-th rising edge with `rst`=0 after the reset edge (32 edges at default).
- **Read latency:** 1 cycle. Address presented before edge N gives data valid after edge N.
- **Write visibility, no bypass:** a write on edge N is visible to reads sampled at edge N+1 (data out after N+1). A read on the same edge N returns the old value.
- **Write visibility, bypass:** a read on edge N returns the new value.
- **Stall:** a stall asserted before edge N holds the data that was output after edge N-1.
- **First accepted write:** on the first edge with `ready`=1 already high, i.e. the edge after `ready` rises.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - Per port, if `enable`=1, `rdAdrs`≠0 and `rdAdrs`==`rsAdrs[i]` on a RUN edge with `stall`=0, `rsData[i] <= rdData`.
  - This gives write-first behaviour.
- Undefined:
  - Read-before-write; a same-edge read returns the pre-write value.
  - No forwarding logic is synthesised.

## Test plan
- **Reset clear:**
  - Stimulus: write 0xDEADBEEF to x5, then pulse `rst` one cycle.
  - Response: `ready` low for exactly 32 edges, then high; reading x5 returns 0.
- **Basic R/W, NRD=3:**
  - Stimulus: write x1=0x11, x2=0x22, x3=0x33; then read ports 0/1/2 = x3/x1/x3.
  - Response: 0x33/0x11/0x33 one cycle later.
- **x0 protection:**
  - Stimulus: write 0xFFFFFFFF to x0; read x0 on all ports.
  - Response: 0 on every port, both with and without bypass.
- **Same-edge write/read on x7:**
  - Stimulus: x7 holds 0xA; write 0xB to x7 while reading x7 on the same edge.
  - Response: 0xB with `REGFILE_BYPASS_EN`, 0xA without; next cycle 0xB in both builds.
- **Stall:**
  - Stimulus: read x4=0x44; assert `stall` for 3 cycles while changing `rsAdrs` to x5 and writing x4=0x99.
  - Response: `rsData` holds 0x44 throughout; after release reads x5, and a later read of x4 gives 0x99.
- **Reset mid-clear / write during clear:**
  - Stimulus: assert `rst` at `cnt`=10 of CLEAR; issue `enable` writes during CLEAR.
  - Response: CLEAR restarts, `ready` rises 32 edges after the second reset, and all registers read 0.
